// File: rtl/pipeline_hazard_ctrl.sv
// Freeze/flush sequencer for the IF/ID and ID/EXE pipeline registers (RAW stalls, branch flush, SRAM wait).
// Optional HAZARD_PERF_CNT_EN adds saturating stall/flush/wait performance counters.
module pipeline_hazard_ctrl #(
  parameter int MAX_STALL = 3,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             forward_en,
  input  logic             id_valid,
  input  logic             id_use_src1,
  input  logic             id_two_src,
  input  logic [3:0]       id_src1,
  input  logic [3:0]       id_src2,
  input  logic [3:0]       exe_dest,
  input  logic             exe_wb_en,
  input  logic             exe_mem_r_en,
  input  logic [3:0]       mem_dest,
  input  logic             mem_wb_en,
  input  logic             exe_br_taken,
  input  logic             sram_busy,
  output logic             freeze_pc,
  output logic             freeze_if_id,
  output logic             freeze_id_exe,
  output logic             freeze_late,
  output logic             flush_if_id,
  output logic             flush_id_exe,
  output logic             stall_err,
  output logic [CNT_W-1:0] perf_stall,
  output logic [CNT_W-1:0] perf_flush,
  output logic [CNT_W-1:0] perf_wait
);

  localparam int SC_W = $clog2(MAX_STALL + 1);

  typedef enum logic [1:0] {RUN, STALL, BR_FLUSH, MEM_WAIT} state_t;

  state_t          state_q, state_d;
  logic [SC_W-1:0] stall_cnt_q, stall_cnt_d;
  logic            err_q, err_hit;
  logic            raw_exe, raw_mem, hz;
  logic            stall_issue;
  logic            fz_pc, fz_if_id, fz_id_exe, fz_late, fl_if_id, fl_id_exe;

  assign raw_exe = exe_wb_en & ((id_use_src1 & (id_src1 == exe_dest)) |
                                (id_two_src  & (id_src2 == exe_dest)));
  assign raw_mem = mem_wb_en & ((id_use_src1 & (id_src1 == mem_dest)) |
                                (id_two_src  & (id_src2 == mem_dest)));
  assign hz = forward_en ? (id_valid & raw_exe & exe_mem_r_en)
                         : (id_valid & (raw_exe | raw_mem));

  // Priority sram_busy > branch > hazard; leaving MEM_WAIT spends one idle cycle in RUN before re-evaluating.
  always_comb begin
    state_d     = RUN;
    stall_issue = 1'b0;
    fz_pc       = 1'b0;
    fz_if_id    = 1'b0;
    fz_id_exe   = 1'b0;
    fz_late     = 1'b0;
    fl_if_id    = 1'b0;
    fl_id_exe   = 1'b0;
    if (state_q == MEM_WAIT && !sram_busy) begin
      state_d = RUN;
    end else if (sram_busy) begin
      fz_pc     = 1'b1;
      fz_if_id  = 1'b1;
      fz_id_exe = 1'b1;
      fz_late   = 1'b1;
      state_d   = MEM_WAIT;
    end else if (exe_br_taken) begin
      fl_if_id  = 1'b1;
      fl_id_exe = 1'b1;
      state_d   = BR_FLUSH;
    end else if (hz && state_q != BR_FLUSH) begin
      fz_pc       = 1'b1;
      fz_if_id    = 1'b1;
      fl_id_exe   = 1'b1;
      stall_issue = 1'b1;
      state_d     = STALL;
    end
  end

  // Consecutive-stall counter saturates at MAX_STALL; the limit is flagged in the cycle that reaches it.
  always_comb begin
    stall_cnt_d = '0;
    if (stall_issue) begin
      if (stall_cnt_q == SC_W'(MAX_STALL)) stall_cnt_d = stall_cnt_q;
      else                                 stall_cnt_d = stall_cnt_q + SC_W'(1);
    end
  end

  assign err_hit = stall_issue && (stall_cnt_q >= SC_W'(MAX_STALL - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      stall_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      err_q       <= err_q | err_hit;
    end
  end

  assign freeze_pc     = rst & fz_pc;
  assign freeze_if_id  = rst & fz_if_id;
  assign freeze_id_exe = rst & fz_id_exe;
  assign freeze_late   = rst & fz_late;
  assign flush_if_id   = rst & fl_if_id;
  assign flush_id_exe  = rst & fl_id_exe;
  assign stall_err     = rst & (err_q | err_hit);

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] cnt_stall_q, cnt_flush_q, cnt_wait_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_stall_q <= '0;
      cnt_flush_q <= '0;
      cnt_wait_q  <= '0;
    end else begin
      if (stall_issue && cnt_stall_q != '1) cnt_stall_q <= cnt_stall_q + CNT_W'(1);
      if (fl_if_id    && cnt_flush_q != '1) cnt_flush_q <= cnt_flush_q + CNT_W'(1);
      if (fz_late     && cnt_wait_q  != '1) cnt_wait_q  <= cnt_wait_q  + CNT_W'(1);
    end
  end

  assign perf_stall = cnt_stall_q;
  assign perf_flush = cnt_flush_q;
  assign perf_wait  = cnt_wait_q;
`else
  assign perf_stall = '0;
  assign perf_flush = '0;
  assign perf_wait  = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl (CNT_W=4 so counter saturation is reachable).
module tb_pipeline_hazard_ctrl;

`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [6:0] IDLE_V  = 7'b0000000;
  localparam logic [6:0] STALL_V = 7'b1100010;
  localparam logic [6:0] WAIT_V  = 7'b1111000;
  localparam logic [6:0] BR_V    = 7'b0000110;
  localparam logic [6:0] ERR_V   = 7'b0000001;

  logic       clk = 1'b0;
  logic       rst;
  logic       forward_en, id_valid, id_use_src1, id_two_src;
  logic [3:0] id_src1, id_src2, exe_dest, mem_dest;
  logic       exe_wb_en, exe_mem_r_en, mem_wb_en, exe_br_taken, sram_busy;
  logic       freeze_pc, freeze_if_id, freeze_id_exe, freeze_late;
  logic       flush_if_id, flush_id_exe, stall_err;
  logic [3:0] perf_stall, perf_flush, perf_wait;

  int checks = 0;
  int errors = 0;

  pipeline_hazard_ctrl #(.MAX_STALL(3), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .forward_en(forward_en), .id_valid(id_valid),
    .id_use_src1(id_use_src1), .id_two_src(id_two_src), .id_src1(id_src1), .id_src2(id_src2),
    .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
    .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .exe_br_taken(exe_br_taken), .sram_busy(sram_busy),
    .freeze_pc(freeze_pc), .freeze_if_id(freeze_if_id), .freeze_id_exe(freeze_id_exe),
    .freeze_late(freeze_late), .flush_if_id(flush_if_id), .flush_id_exe(flush_id_exe),
    .stall_err(stall_err), .perf_stall(perf_stall), .perf_flush(perf_flush), .perf_wait(perf_wait)
  );

  always #5 clk = ~clk;

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic fwd, input logic valid, input logic use1, input logic two,
                               input logic [3:0] s1, input logic [3:0] s2,
                               input logic [3:0] ed, input logic ewb, input logic emr,
                               input logic [3:0] md, input logic mwb,
                               input logic br, input logic busy);
    forward_en = fwd;  id_valid = valid;  id_use_src1 = use1;  id_two_src = two;
    id_src1 = s1;      id_src2 = s2;      exe_dest = ed;       exe_wb_en = ewb;
    exe_mem_r_en = emr; mem_dest = md;    mem_wb_en = mwb;     exe_br_taken = br;
    sram_busy = busy;
  endtask

  task automatic idleInputs();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // ID reads R3 while EXE writes R3, no forwarding
  task automatic exeHazard(input logic br, input logic busy);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'd3, 4'd0, 4'd3, 1'b1, 1'b0, 4'd0, 1'b0, br, busy);
  endtask

  task automatic checkOutput(input string tag, input logic [6:0] expected);
    logic [6:0] observed;
    #1;
    observed = {freeze_pc, freeze_if_id, freeze_id_exe, freeze_late, flush_if_id, flush_id_exe, stall_err};
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  task automatic checkPerf(input string tag, input logic [3:0] observed, input logic [3:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  initial begin
    rst = 1'b0;
    exeHazard(1'b1, 1'b1);
    checkOutput("reset_forces_zero", IDLE_V);
    checkPerf("reset_perf_stall", perf_stall, 4'd0);
    idleInputs();
    nextCycle();
    rst = 1'b1;
    checkOutput("idle_after_reset", IDLE_V);

    // RAW against EXE then the same producer in MEM
    nextCycle();
    exeHazard(1'b0, 1'b0);
    checkOutput("t1_exe_raw_stall", STALL_V);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'd3, 4'd0, 4'd0, 1'b0, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0);
    checkOutput("t1_mem_raw_stall", STALL_V);
    nextCycle();
    idleInputs();
    checkOutput("t1_back_to_run", IDLE_V);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'd3, 4'd0, 4'd3, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("t1_bubble_no_stall", IDLE_V);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd3, 4'd3, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("t1_src2_unused", IDLE_V);

    // Load-use with forwarding: one stall cycle
    nextCycle();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 4'd0, 4'd5, 4'd5, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("t2_load_use_stall", STALL_V);
    nextCycle();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 4'd0, 4'd5, 4'd0, 1'b0, 1'b0, 4'd5, 1'b1, 1'b0, 1'b0);
    checkOutput("t2_forwarded_release", IDLE_V);
    nextCycle();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 4'd0, 4'd5, 4'd5, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("t2_alu_forwarded", IDLE_V);

    // Branch beats a concurrent hazard; hazard masked in BR_FLUSH
    nextCycle();
    exeHazard(1'b1, 1'b0);
    checkOutput("t3_branch_over_hz", BR_V);
    nextCycle();
    exeHazard(1'b0, 1'b0);
    checkOutput("t3_brflush_masks_hz", IDLE_V);
    nextCycle();
    checkOutput("t3_hz_after_flush", STALL_V);
    nextCycle();
    idleInputs();
    checkOutput("t3_idle", IDLE_V);

    // SRAM wait interrupting a stall
    nextCycle();
    exeHazard(1'b0, 1'b0);
    checkOutput("t4_stall", STALL_V);
    nextCycle();
    exeHazard(1'b0, 1'b1);
    checkOutput("t4_wait_1", WAIT_V);
    for (int i = 2; i <= 4; i++) begin
      nextCycle();
      checkOutput($sformatf("t4_wait_%0d", i), WAIT_V);
    end
    nextCycle();
    exeHazard(1'b0, 1'b0);
    checkOutput("t4_wait_release", IDLE_V);
    nextCycle();
    checkOutput("t4_pending_stall", STALL_V);
    nextCycle();
    idleInputs();
    checkOutput("t4_idle", IDLE_V);
    checkPerf("t4_perf_stall", perf_stall, PERF ? 4'd6 : 4'd0);
    checkPerf("t4_perf_flush", perf_flush, PERF ? 4'd1 : 4'd0);
    checkPerf("t4_perf_wait",  perf_wait,  PERF ? 4'd4 : 4'd0);

    // Five consecutive stalls with MAX_STALL=3
    nextCycle();
    exeHazard(1'b0, 1'b0);
    checkOutput("t5_stall_1", STALL_V);
    nextCycle();
    checkOutput("t5_stall_2", STALL_V);
    nextCycle();
    checkOutput("t5_stall_3_err", STALL_V | ERR_V);
    nextCycle();
    checkOutput("t5_stall_4_err", STALL_V | ERR_V);
    nextCycle();
    checkOutput("t5_stall_5_err", STALL_V | ERR_V);
    nextCycle();
    idleInputs();
    checkOutput("t5_err_sticky", ERR_V);
    exeHazard(1'b0, 1'b0);
    #1;
    rst = 1'b0;
    checkOutput("t5_async_reset", IDLE_V);
    idleInputs();
    nextCycle();
    rst = 1'b1;
    checkOutput("t5_err_cleared", IDLE_V);

    // Reset in the middle of a wait
    nextCycle();
    exeHazard(1'b0, 1'b1);
    checkOutput("rw_wait", WAIT_V);
    nextCycle();
    rst = 1'b0;
    checkOutput("rw_reset_releases", IDLE_V);
    idleInputs();
    nextCycle();
    rst = 1'b1;
    checkOutput("rw_run_after_reset", IDLE_V);
    checkPerf("rw_perf_wait_clr", perf_wait, 4'd0);

    // Twenty stall cycles saturate a 4-bit counter
    nextCycle();
    exeHazard(1'b0, 1'b0);
    for (int i = 0; i < 20; i++) nextCycle();
    checkOutput("t6_long_stall", STALL_V | ERR_V);
    checkPerf("t6_perf_stall_sat", perf_stall, PERF ? 4'd15 : 4'd0);
    checkPerf("t6_perf_flush", perf_flush, 4'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
